// File: rtl/tt_and_req_responder.sv
// Purpose: responder end of a 4-phase req/ack word handshake that AND-reduces N_OPS operands.
// Latency: req edge to ack edge is 3 cycles (2-flop synchroniser plus 1 registered FSM stage).
// Backpressure: the host may not raise req again until ack drops; a stuck req aborts with a sticky error.
module tt_and_req_responder #(
  parameter int WIDTH   = 8,
  parameter int N_OPS   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] din,
  output logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       op_cnt,
  output logic             timeout_err
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [3:0]       OPS_LAST = 4'(N_OPS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic             req_meta_q, req_meta_d;
  logic             req_s_q,    req_s_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic [WIDTH-1:0] dout_q,     dout_d;
  logic [3:0]       op_cnt_q,   op_cnt_d;
  logic             ack_q,      ack_d;
  logic             err_q,      err_d;
  logic [TMO_W-1:0] tmo_q,      tmo_d;

  // Next-state: synchroniser shift, one capture per synchronised req high phase, timeout abort.
  always_comb begin
    req_meta_d = req;
    req_s_d    = req_meta_q;
    state_d    = state_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    op_cnt_d   = op_cnt_q;
    ack_d      = ack_q;
    err_d      = err_q;
    tmo_d      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (req_s_q) begin
          acc_d    = acc_q & din;
          op_cnt_d = op_cnt_q + 4'd1;
          ack_d    = 1'b1;
          tmo_d    = '0;
          state_d  = S_ACK;
          // Publish the result on the same edge as the final ack so it is valid while ack=1.
          if ((op_cnt_q + 4'd1) == OPS_LAST) begin
            dout_d = acc_q & din;
          end
        end
      end
      S_ACK: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
          if (op_cnt_q == OPS_LAST) begin
            op_cnt_d = 4'd0;
            acc_d    = '1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Host never released req: drop the partial transaction but keep the last result.
          err_d    = 1'b1;
          ack_d    = 1'b0;
          op_cnt_d = 4'd0;
          acc_d    = '1;
          state_d  = S_ABORT;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ABORT: begin
        if (!req_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      acc_q      <= '1;
      dout_q     <= '0;
      op_cnt_q   <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_meta_q <= req_meta_d;
      req_s_q    <= req_s_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      op_cnt_q   <= op_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ack         = ack_q;
  assign dout        = dout_q;
  assign op_cnt      = op_cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_tt_and_req_responder.sv
// Bench for tt_and_req_responder: directed scenarios plus randomized handshakes,
// compared every cycle against an operand-queue model of the protocol.
module tb_tt_and_req_responder;

  localparam int W    = 8;
  localparam int NOPS = 2;
  localparam int TMO  = 8;

  logic         clk;
  logic         rst;
  logic         req;
  logic [W-1:0] din;
  logic         ack;
  logic [W-1:0] dout;
  logic [3:0]   op_cnt;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  tt_and_req_responder #(.WIDTH(W), .N_OPS(NOPS), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .ack        (ack),
    .dout       (dout),
    .op_cnt     (op_cnt),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: captured operands kept in a queue; ack/timeout timed by edge counts.
  logic         m_ack;
  logic         m_abort;
  logic         m_err;
  logic [W-1:0] m_dout;
  logic [W-1:0] m_ops[$];
  int           m_rise;
  int           edge_n;
  logic         h0, h1;

  initial begin
    logic         rs;
    logic [W-1:0] a;
    m_ack = 0; m_abort = 0; m_err = 0; m_dout = '0;
    m_rise = 0; edge_n = 0; h0 = 0; h1 = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        h0 = 0; h1 = 0;
        m_ack = 0; m_abort = 0; m_err = 0; m_dout = '0;
        m_ops.delete();
      end else begin
        rs = h1;       // req as sampled two edges ago
        h1 = h0;
        h0 = req;
        if (m_abort) begin
          if (!rs) m_abort = 0;
        end else if (!m_ack) begin
          if (rs) begin
            m_ops.push_back(din);
            m_ack  = 1;
            m_rise = edge_n;
            if (m_ops.size() == NOPS) begin
              a = '1;
              foreach (m_ops[i]) a = a & m_ops[i];
              m_dout = a;
            end
          end
        end else begin
          if (!rs) begin
            m_ack = 0;
            if (m_ops.size() == NOPS) m_ops.delete();
          end else if (edge_n - m_rise == TMO) begin
            m_err   = 1;
            m_ack   = 0;
            m_abort = 1;
            m_ops.delete();
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_ack",    {31'd0, ack},         {31'd0, m_ack});
        chk("cyc_dout",   {24'd0, dout},        {24'd0, m_dout});
        chk("cyc_op_cnt", {28'd0, op_cnt},      m_ops.size());
        chk("cyc_err",    {31'd0, timeout_err}, {31'd0, m_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    while (ack !== v && n < 40) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, ack}, {31'd0, v});
  endtask

  task automatic up(input logic [W-1:0] d);
    req = 1'b1;
    din = d;
    wait_ack(1'b1, "ack_rise");
  endtask

  task automatic down();
    req = 1'b0;
    wait_ack(1'b0, "ack_fall");
    tick();
  endtask

  task automatic hold(input int n, input bit scramble);
    for (int i = 0; i < n; i++) begin
      tick();
      if (scramble) din = 8'($urandom);
    end
  endtask

  initial begin
    int r;
    rst = 1'b1;
    req = 1'b0;
    din = '0;

    // Reset
    tick();
    tick();
    chk_en = 1;
    chk("rst_ack",    {31'd0, ack},         32'd0);
    chk("rst_dout",   {24'd0, dout},        32'd0);
    chk("rst_op_cnt", {28'd0, op_cnt},      32'd0);
    chk("rst_err",    {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic two-operand transaction
    up(8'hF0);
    down();
    up(8'h3C);
    chk("basic_dout_during_ack", {24'd0, dout},   32'h30);
    chk("basic_op_cnt_full",     {28'd0, op_cnt}, 32'd2);
    down();
    chk("basic_op_cnt_cleared",  {28'd0, op_cnt}, 32'd0);

    // Latency: ack follows req edges by exactly 3 edges
    req = 1'b1;
    din = 8'h12;
    tick();
    tick();
    chk("lat_rise_k2", {31'd0, ack}, 32'd0);
    tick();
    chk("lat_rise_k3", {31'd0, ack}, 32'd1);
    req = 1'b0;
    tick();
    tick();
    chk("lat_fall_m2", {31'd0, ack}, 32'd1);
    tick();
    chk("lat_fall_m3", {31'd0, ack}, 32'd0);
    tick();
    up(8'h34);
    down();
    chk("lat_dout", {24'd0, dout}, 32'h10);

    // Timeout: req held high well past TIMEOUT
    up(8'hC3);
    hold(20, 1'b0);
    chk("tmo_err",    {31'd0, timeout_err}, 32'd1);
    chk("tmo_ack",    {31'd0, ack},         32'd0);
    chk("tmo_dout",   {24'd0, dout},        32'h10);
    chk("tmo_op_cnt", {28'd0, op_cnt},      32'd0);
    down();
    up(8'hFF);
    down();
    up(8'h0F);
    down();
    chk("tmo_after_dout", {24'd0, dout},        32'h0F);
    chk("tmo_after_err",  {31'd0, timeout_err}, 32'd1);

    // Reset mid-transaction discards the captured operand
    up(8'hAA);
    down();
    chk("mid_op_cnt_before", {28'd0, op_cnt}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_op_cnt", {28'd0, op_cnt},      32'd0);
    chk("mid_dout",   {24'd0, dout},        32'd0);
    chk("mid_err",    {31'd0, timeout_err}, 32'd0);
    tick();
    up(8'h55);
    down();
    up(8'hFF);
    down();
    chk("mid_dout_after", {24'd0, dout}, 32'h55);

    // din changes while ack=1 are ignored
    for (int t = 0; t < 2; t++) begin
      up(8'hFF);
      hold(3, 1'b1);
      down();
      up(8'h81);
      hold(3, 1'b1);
      chk("hold_dout_ack", {24'd0, dout}, 32'h81);
      down();
      chk("hold_dout_done", {24'd0, dout}, 32'h81);
    end

    // Randomized traffic: normal handshakes, glitches, stuck hosts, resets
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        req = 1'b1;
        din = 8'($urandom);
        tick();
        req = 1'b0;
        hold(5, 1'b0);
      end else if (r == 1) begin
        up(8'($urandom | $urandom));
        hold(12, 1'b1);
        down();
      end else if (r == 2) begin
        up(8'($urandom | $urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        down();
        hold(3, 1'b0);
      end else begin
        up(8'($urandom | $urandom));
        hold(int'($urandom_range(0, 3)), 1'b1);
        down();
        hold(int'($urandom_range(0, 2)), 1'b0);
      end
    end

    hold(6, 1'b0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
